// File: rtl/avalon_multi_interval_timer.sv
// Avalon-MM bank of NUM_CH down-counting interval timers sharing one prescaler.
// Ports: clk, reset_n (async low), address/chipselect/write_n/writedata in,
//   readdata (registered, 1-cycle latency) and irq (|(TO & ITO)) out.
module avalon_multi_interval_timer #(
   parameter int          NUM_CH     = 4,
   parameter int          COUNT_W    = 32,
   parameter int          PRESC_W    = 8,
   parameter logic [31:0] PERIOD_RST = 32'h0000C34F,
   parameter int          ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam logic [COUNT_W-1:0] PRST   = PERIOD_RST[COUNT_W-1:0];
   localparam logic [ADDR_W-1:0]  A_PRSC = ADDR_W'(4*NUM_CH);
   localparam logic [ADDR_W-1:0]  A_PEND = ADDR_W'(4*NUM_CH+1);

   logic               wr;
   logic               tick;
   logic               pend_wr;
   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] pcnt_q;
   logic [31:0]        rd_d;

   logic [NUM_CH-1:0]  run_v;
   logic [NUM_CH-1:0]  to_v;
   logic [NUM_CH-1:0]  ito_v;
   logic [3:0]         ctrl_v   [NUM_CH];
   logic [COUNT_W-1:0] period_v [NUM_CH];
   logic [COUNT_W-1:0] snap_v   [NUM_CH];

   assign wr      = chipselect & ~write_n;
   assign pend_wr = wr && (address == A_PEND);
   assign tick    = (pcnt_q == presc_q);

   // Shared prescaler: presc_cnt runs 0..PRESCALE; a PRESCALE write restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else if (wr && (address == A_PRSC)) begin
         presc_q <= writedata[PRESC_W-1:0];
         pcnt_q  <= '0;
      end else if (tick) begin
         pcnt_q  <= '0;
      end else begin
         pcnt_q  <= pcnt_q + PRESC_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [ADDR_W-1:0] A_ST = ADDR_W'(4*i);
      localparam logic [ADDR_W-1:0] A_CT = ADDR_W'(4*i+1);
      localparam logic [ADDR_W-1:0] A_PE = ADDR_W'(4*i+2);
      localparam logic [ADDR_W-1:0] A_SN = ADDR_W'(4*i+3);

      logic               st_wr, ct_wr, pe_wr, sn_wr;
      logic               tmo, to_clr;
      logic               run_q, to_q, fr_q;
      logic [3:0]         ctrl_q;
      logic [COUNT_W-1:0] period_q, count_q, snap_q;

      assign st_wr  = wr && (address == A_ST);
      assign ct_wr  = wr && (address == A_CT);
      assign pe_wr  = wr && (address == A_PE);
      assign sn_wr  = wr && (address == A_SN);
      // force_reload outranks a timeout in the same cycle.
      assign tmo    = run_q & tick & (count_q == '0) & ~fr_q;
      assign to_clr = st_wr | (pend_wr & writedata[i]);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            fr_q     <= 1'b0;
            ctrl_q   <= '0;
            period_q <= PRST;
            count_q  <= PRST;
            snap_q   <= '0;
         end else begin
            fr_q <= pe_wr;
            if (pe_wr) period_q <= writedata[COUNT_W-1:0];
            if (ct_wr) ctrl_q <= writedata[3:0];
            if (sn_wr) snap_q <= count_q;

            if (fr_q)
               count_q <= period_q;
            else if (tmo)
               count_q <= period_q;
            else if (run_q && tick)
               count_q <= count_q - COUNT_W'(1);

            // Latest software intent first: START beats STOP and reload.
            if (ct_wr && writedata[2])
               run_q <= 1'b1;
            else if (ct_wr && writedata[3])
               run_q <= 1'b0;
            else if (fr_q)
               run_q <= 1'b0;
            else if (tmo && !ctrl_q[1])
               run_q <= 1'b0;

            if (to_clr)
               to_q <= 1'b0;
            else if (tmo)
               to_q <= 1'b1;
         end
      end

      assign run_v[i]    = run_q;
      assign to_v[i]     = to_q;
      assign ito_v[i]    = ctrl_q[0];
      assign ctrl_v[i]   = ctrl_q;
      assign period_v[i] = period_q;
      assign snap_v[i]   = snap_q;
   end

   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == ADDR_W'(4*i))
            rd_d = {30'b0, run_v[i], to_v[i]};
         if (address == ADDR_W'(4*i+1))
            rd_d = {28'b0, ctrl_v[i]};
         if (address == ADDR_W'(4*i+2))
            rd_d = 32'(period_v[i]);
         if (address == ADDR_W'(4*i+3))
            rd_d = 32'(snap_v[i]);
      end
      if (address == A_PRSC) rd_d = 32'(presc_q);
      if (address == A_PEND) rd_d = 32'(to_v);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_d;
   end

   assign irq = |(to_v & ito_v);

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Directed bench for avalon_multi_interval_timer.
// Read expectations go through a queue and are checked when readdata lands.
module tb_avalon_multi_interval_timer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;

   int tests = 0;
   int fails = 0;
   int n;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   localparam logic [4:0] PRSC = 5'd16;
   localparam logic [4:0] PEND = 5'd17;

   avalon_multi_interval_timer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ra(int ch, int r);
      return 5'(4*ch + r);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(logic [4:0] a, logic [31:0] expv, string tag);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      chk(tag_q.pop_front(), readdata, exp_q.pop_front());
      chipselect = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      rd(ra(0,0), 32'h0, "rst_status0");
      rd(ra(0,2), 32'h0000C34F, "rst_period0");
      rd(ra(0,1), 32'h0, "rst_ctrl0");
      rd(PRSC, 32'h0, "rst_prescale");

      // Reset in the middle of a running count.
      wr(ra(0,1), 32'h5);
      repeat (3) @(posedge clk);
      rd(ra(0,0), 32'h2, "midrun_status0");
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_readdata", readdata, 32'h0);
      chk("async_rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(ra(0,0), 32'h0, "post_rst_status0");
      wr(ra(0,3), 32'h0);
      rd(ra(0,3), 32'h0000C34F, "post_rst_counter0");

      // ch1 continuous, period 4, tick every cycle.
      wr(ra(1,2), 32'd4);
      wr(ra(1,1), 32'h7);
      repeat (4) @(posedge clk);
      #1 chk("ch1_irq_early", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1 chk("ch1_irq_5th", {31'b0, irq}, 32'h1);
      wr(ra(1,0), 32'h0);
      chk("ch1_irq_clr", {31'b0, irq}, 32'h0);
      repeat (3) @(posedge clk);
      #1 chk("ch1_irq_gap", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1 chk("ch1_irq_2nd", {31'b0, irq}, 32'h1);
      rd(ra(1,0), 32'h3, "ch1_status");
      wr(ra(1,1), 32'h8);
      chk("ch1_ito_off", {31'b0, irq}, 32'h0);
      wr(ra(1,0), 32'h0);
      rd(ra(1,0), 32'h0, "ch1_stopped");

      // ch2 one-shot, period 3, prescale 2.
      wr(ra(2,2), 32'd3);
      wr(PRSC, 32'd2);
      wr(ra(2,1), 32'h5);
      n = 0;
      while (!irq && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ch2_latency", 32'(n), 32'd10);
      rd(ra(2,0), 32'h1, "ch2_status");
      wr(ra(2,3), 32'h0);
      rd(ra(2,3), 32'd3, "ch2_counter");
      repeat (8) @(posedge clk);
      wr(ra(2,3), 32'h0);
      rd(ra(2,3), 32'd3, "ch2_counter_hold");
      wr(PEND, 32'h4);
      rd(PEND, 32'h0, "ch2_w1c");
      chk("ch2_irq_clr", {31'b0, irq}, 32'h0);
      wr(PRSC, 32'd0);

      // Snapshot and mid-run PERIOD write on ch0.
      wr(ra(0,2), 32'd100);
      wr(ra(0,1), 32'h4);
      repeat (10) @(posedge clk);
      wr(ra(0,3), 32'h0);
      rd(ra(0,3), 32'd90, "snap_90");
      wr(ra(0,2), 32'd50);
      @(posedge clk);
      rd(ra(0,0), 32'h0, "reload_run_clr");
      wr(ra(0,3), 32'h0);
      rd(ra(0,3), 32'd50, "reload_counter");

      // Timeout coinciding with a PENDING W1C.
      wr(ra(0,2), 32'd2);
      wr(ra(0,1), 32'h6);
      repeat (2) @(posedge clk);
      wr(PEND, 32'h1);
      rd(PEND, 32'h0, "w1c_beats_set");
      wr(ra(0,1), 32'h8);
      wr(PEND, 32'h1);
      rd(ra(0,0), 32'h0, "ch0_stopped");
      wr(ra(0,1), 32'hC);
      rd(ra(0,0), 32'h2, "start_beats_stop");
      rd(ra(0,1), 32'hC, "ctrl_readback");
      wr(PEND, 32'h1);

      // Two channels with different periods.
      wr(ra(0,2), 32'd2);
      wr(ra(3,2), 32'd6);
      wr(ra(0,1), 32'h7);
      wr(ra(3,1), 32'h7);
      rd(PEND, 32'h1, "pend_0001");
      repeat (6) @(posedge clk);
      rd(PEND, 32'h9, "pend_1001");
      wr(PEND, 32'h8);
      rd(PEND, 32'h1, "pend_after_w1c");
      chk("multi_irq", {31'b0, irq}, 32'h1);
      wr(ra(3,1), 32'h8);
      chk("multi_irq_ch0", {31'b0, irq}, 32'h1);
      wr(ra(0,1), 32'h2);
      chk("ito0_off", {31'b0, irq}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/avalon_multi_interval_timer.md
Name: avalon_multi_interval_timer

Overview:
Avalon-MM slave holding NUM_CH independent down-counting interval timers behind one shared clock prescaler. It generalises the single 16-bit-bus system timer: parametrised counter width and channel count, per-channel one-shot/continuous mode, an irq-pending vector, and a single combined irq line to the CPU. It sits on the SoC peripheral bus beside the existing timer and generates game tick, animation and timeout interrupts.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
COUNT_W, 32, counter/period width in bits (1..32)
PRESC_W, 8, shared prescaler width
PERIOD_RST, 32'h0000C34F, reset value of every period and counter, truncated to COUNT_W
ADDR_W, 5, address width; must satisfy 2^ADDR_W >= 4*NUM_CH+2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  OR of all enabled pending channel timeouts

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). Every flop clears on reset_n low, regardless of clk.
- Reset values: readdata=0, irq=0, control=0, run=0, TO=0, snapshot=0, prescale=0, presc_cnt=0, period=counter=PERIOD_RST.
- Write strobe: chipselect & ~write_n. Reads have 1-cycle latency: readdata is registered from the read mux every cycle. Unmapped addresses read 0. Writes to unmapped addresses are ignored.
- Per-channel map, base b=4*ch:
  - b+0 STATUS: read {30'b0, RUN, TO}. Any write clears TO.
  - b+1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits 3:0 are stored and read back. START and STOP act as strobes.
  - b+2 PERIOD: COUNT_W bits, zero-extended on read.
  - b+3 SNAP: a write captures the live counter into snapshot. A read returns snapshot.
- Global registers:
  - 4*NUM_CH PRESCALE: PRESC_W bits.
  - 4*NUM_CH+1 PENDING: read {TO[NUM_CH-1:0]}. A write clears TO[i] for each writedata[i]=1 (W1C).
- Prescaler:
  - presc_cnt counts 0..PRESCALE, then wraps. tick=1 in the cycle presc_cnt==PRESCALE.
  - PRESCALE=0 gives tick every cycle.
  - A PRESCALE write resets presc_cnt to 0.
- Channel counter update, in priority order:
  1. force_reload: set the cycle after a PERIOD write. Loads period and clears RUN.
  2. RUN & tick & counter==0: loads period and sets TO. If CONT=0, RUN clears in the same edge.
  3. RUN & tick: counter decrements by 1.
  4. Otherwise the counter holds.
- Timeout period is (period+1) ticks. period=0 with CONT=1 sets TO on every tick.
- RUN control:
  - START sets RUN.
  - STOP or force_reload clears RUN.
  - START and STOP written together: START wins.
  - START while RUN is already set has no effect on the counter.
- TO set versus clear in the same cycle (STATUS write or PENDING W1C): clear wins.
- irq is combinational: |(TO & ITO). It deasserts the cycle after TO is cleared or ITO is written to 0.
- Counter arithmetic is COUNT_W wide with no wrap below 0, because rule 2 intercepts zero.
- Channels are fully independent and share only tick.

Test Plan:
- Reset mid-count: reset_n low for 1 cycle while ch0 is running -> counter=PERIOD_RST, RUN=0, irq=0 immediately; the next readdata is 0.
- ch1 continuous: PERIOD=4, PRESCALE=0, CONTROL=4'b0111 -> TO sets 5 cycles after run starts, then every 5 cycles; irq rises; STATUS write clears it; irq is 0 the next cycle.
- ch2 one-shot: PERIOD=3, PRESCALE=2, CONTROL=4'b0101 -> TO sets after 12 clk; STATUS reads 2'b01 (RUN=0); counter=3 and holds.
- Snapshot: run ch0 with PERIOD=100, write SNAP after 10 ticks -> SNAP read returns 90 (±1 per documented latency); PERIOD write mid-run -> RUN=0, counter=new period.
- Simultaneous events: timeout coincides with a PENDING W1C of that bit -> TO stays 0; CONTROL=4'b1100 -> RUN=1.
- Multi-channel: ch0 PERIOD=2, ch3 PERIOD=6, both ITO/CONT -> PENDING reads 4'b0001 then 4'b1001; writing 4'b1000 to PENDING leaves 4'b0001 and irq stays 1.
